mem_access_ctrl: RTL and testbench

//  Sequences one external async-SRAM read or write per request on behalf of the datapath.

---
 rtl/mem_access_ctrl_pkg.sv | 18 +
 rtl/mem_access_ctrl_wait_counter.sv | 27 ++
 rtl/mem_access_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the SLC-3 memory access controller.
// MMIO_ADDR only takes effect when the MMIO_EN macro is defined.
package slc3_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        DONE
    } mem_state_t;

    localparam logic [15:0] MMIO_ADDR = 16'hFFFF;

    localparam int WORD_W = 16;
    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Four-bit loadable down-counter that times the SRAM strobe width.
// The zero flag marks the final cycle of the strobe window.
module mem_wait_counter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count;

    // Load on entry to the strobe window, then count down and stop at zero
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences one async-SRAM read or write per datapath request.
// Optional feature: define MMIO_EN so that address 16'hFFFF maps to the
// board switches (read) and the hex display register (write) instead of SRAM.
module mem_access_ctrl
    import slc3_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_resp,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] switches,
    output logic [DATA_W-1:0] hex_out
);

    generate
        if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_bad_wait
            $error("mem_access_ctrl: WAIT_CYCLES must be in 1..15");
        end
    endgenerate

    mem_state_t state;
    mem_state_t next_state;
    logic       is_write;
    logic       is_mmio;
    logic       accept;
    logic       cnt_zero;

    assign accept = (state == IDLE) && (req_rd || req_wr);

    mem_wait_counter u_wait_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (state == SETUP),
        .load_val (4'(WAIT_CYCLES - 1)),
        .dec      (state == ACCESS),
        .zero     (cnt_zero)
    );

    // State register; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: writes take an extra HOLD cycle, MMIO skips the SRAM
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_rd || req_wr) next_state = SETUP;
            SETUP:   next_state = is_mmio ? DONE : ACCESS;
            ACCESS:  if (cnt_zero) next_state = is_write ? HOLD : DONE;
            HOLD:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobe and handshake decode from the current state
    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        mem_resp   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            SETUP: begin
                if (!is_mmio) begin
                    sram_ce_n  = 1'b0;
                    sram_dq_oe = is_write;
                end
            end
            ACCESS: begin
                sram_ce_n = 1'b0;
                if (is_write) begin
                    sram_we_n  = 1'b0;
                    sram_dq_oe = 1'b1;
                end else begin
                    sram_oe_n = 1'b0;
                end
            end
            HOLD: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
            end
            DONE:    mem_resp = 1'b1;
            default: ;
        endcase
    end

    // Capture the request at accept; later addr/wdata changes are ignored
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            is_write    <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
        end else if (accept) begin
            is_write    <= req_wr;
            sram_addr   <= addr;
            sram_dq_out <= wdata;
        end
    end

`ifdef MMIO_EN
    // Remember whether the accepted access targets the MMIO address
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            is_mmio <= 1'b0;
        end else if (accept) begin
            is_mmio <= (addr == ADDR_W'(MMIO_ADDR));
        end
    end

    // Hex display register written by MMIO stores during SETUP
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hex_out <= '0;
        end else if ((state == SETUP) && is_mmio && is_write) begin
            hex_out <= sram_dq_out;
        end
    end

    // Read data from the SRAM on the last strobe cycle, or from the switches
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if ((state == ACCESS) && !is_write && cnt_zero) begin
            rdata <= sram_dq_in;
        end else if ((state == SETUP) && is_mmio && !is_write) begin
            rdata <= switches;
        end
    end
`else
    logic unused_switches;

    assign is_mmio         = 1'b0;
    assign hex_out         = '0;
    assign unused_switches = ^switches;

    // Read data captured from the SRAM on the last strobe cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if ((state == ACCESS) && !is_write && cnt_zero) begin
            rdata <= sram_dq_in;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a behavioural SRAM.
// Build with MMIO_EN defined to exercise the switch/hex MMIO path.
module tb_mem_access_ctrl;
    import slc3_mem_pkg::*;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int WAIT_CYCLES = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_rd;
    logic              req_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              mem_resp;
    logic              busy;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic [DATA_W-1:0] sram_dq_in;
    logic [DATA_W-1:0] sram_dq_out;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] switches;
    logic [DATA_W-1:0] hex_out;

    int   checks = 0;
    int   errors = 0;
    logic illegal_seen = 1'b0;
    word_t sram [0:65535];

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .mem_resp    (mem_resp),
        .busy        (busy),
        .sram_addr   (sram_addr),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .switches    (switches),
        .hex_out     (hex_out)
    );

    // Behavioural async SRAM: combinational read, store while WE is low
    assign sram_dq_in = sram[sram_addr];
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;
    end

    // Watch for overlapping strobes or bus contention on every cycle
    always @(negedge clk) begin
        if ((!sram_oe_n && !sram_we_n) || (sram_dq_oe && !sram_oe_n)) illegal_seen = 1'b1;
    end

    // Global time limit so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_rd = rd;
        req_wr = wr;
        addr   = a;
        wdata  = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One complete access starting now (cycle 0); returns response cycle and whether OE went low
    task automatic runAccess(input logic rd, input logic wr,
                             input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             output int lat, output logic oe_low);
        lat    = -1;
        oe_low = 1'b0;
        applyStimulus(rd, wr, a, d);
        for (int c = 1; (c <= 20) && (lat < 0); c++) begin
            nextCycle();
            if (!sram_oe_n) oe_low = 1'b1;
            if (mem_resp) begin
                lat = c;
                applyStimulus(1'b0, 1'b0, a, d);
            end
        end
        applyStimulus(1'b0, 1'b0, a, d);
        nextCycle();
    endtask

    initial begin
        int   lat;
        logic oe_low;
        logic flag;

        reset_n  = 1'b0;
        switches = 16'h00C3;
        applyStimulus(1'b0, 1'b0, '0, '0);
        sram[16'h3000] = 16'h1234;
        repeat (3) nextCycle();

        $display("[TB] reset state");
        checkOutput("reset_ctrl", {busy, mem_resp, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 6'b001110);
        checkOutput("reset_rdata", rdata, 16'h0000);
        checkOutput("reset_regs", {sram_addr, sram_dq_out, hex_out}, 48'h0);
        reset_n = 1'b1;
        nextCycle();

        $display("[TB] read with cycle-by-cycle strobes");
        applyStimulus(1'b1, 1'b0, 16'h3000, 16'h0000);
        nextCycle();
        checkOutput("rd_c1_setup", {busy, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, mem_resp}, 6'b101100);
        applyStimulus(1'b0, 1'b0, 16'h3000, 16'h0000);
        nextCycle();
        checkOutput("rd_c2_access", {busy, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, mem_resp}, 6'b100100);
        nextCycle();
        checkOutput("rd_c3_access", {busy, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, mem_resp}, 6'b100100);
        nextCycle();
        checkOutput("rd_c4_done", {busy, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, mem_resp}, 6'b111101);
        checkOutput("rd_c4_rdata", rdata, 16'h1234);
        checkOutput("rd_sram_addr", sram_addr, 16'h3000);
        nextCycle();
        checkOutput("rd_c5_idle", {busy, mem_resp}, 2'b00);

        $display("[TB] write with cycle-by-cycle strobes");
        applyStimulus(1'b0, 1'b1, 16'h0042, 16'hBEEF);
        nextCycle();
        checkOutput("wr_c1_setup", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, mem_resp}, 5'b01110);
        checkOutput("wr_dq_out", sram_dq_out, 16'hBEEF);
        applyStimulus(1'b0, 1'b0, 16'h1111, 16'h2222);
        nextCycle();
        checkOutput("wr_c2_access", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, mem_resp}, 5'b01010);
        nextCycle();
        checkOutput("wr_c3_access", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, mem_resp}, 5'b01010);
        nextCycle();
        checkOutput("wr_c4_hold", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, mem_resp}, 5'b01110);
        nextCycle();
        checkOutput("wr_c5_done", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, mem_resp}, 5'b11101);
        checkOutput("wr_rdata_kept", rdata, 16'h1234);
        nextCycle();
        runAccess(1'b1, 1'b0, 16'h0042, 16'h0000, lat, oe_low);
        checkOutput("wr_readback_lat", lat, 32'd4);
        checkOutput("wr_readback_data", rdata, 16'hBEEF);

        $display("[TB] simultaneous read and write requests");
        runAccess(1'b1, 1'b1, 16'h0010, 16'h00AA, lat, oe_low);
        checkOutput("both_lat", lat, 32'd5);
        checkOutput("both_no_oe", oe_low, 1'b0);
        checkOutput("both_rdata_kept", rdata, 16'hBEEF);
        runAccess(1'b1, 1'b0, 16'h0010, 16'h0000, lat, oe_low);
        checkOutput("both_readback", rdata, 16'h00AA);

        $display("[TB] reset during write access");
        applyStimulus(1'b0, 1'b1, 16'h0050, 16'h5555);
        repeat (3) nextCycle();
        reset_n = 1'b0;
        nextCycle();
        checkOutput("abort_ctrl", {busy, mem_resp, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 6'b001110);
        checkOutput("abort_rdata", rdata, 16'h0000);
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        flag = 1'b0;
        for (int c = 0; c < 6; c++) begin
            nextCycle();
            if (mem_resp || busy) flag = 1'b1;
        end
        checkOutput("abort_no_resp", flag, 1'b0);
        runAccess(1'b0, 1'b1, 16'h0060, 16'h7777, lat, oe_low);
        checkOutput("after_abort_wr_lat", lat, 32'd5);
        runAccess(1'b1, 1'b0, 16'h0060, 16'h0000, lat, oe_low);
        checkOutput("after_abort_rd_lat", lat, 32'd4);
        checkOutput("after_abort_rd_data", rdata, 16'h7777);

        $display("[TB] back-to-back reads with request held high");
        applyStimulus(1'b1, 1'b0, 16'h3000, 16'h0000);
        repeat (4) nextCycle();
        checkOutput("b2b_first_resp", {mem_resp, rdata}, {1'b1, 16'h1234});
        sram[16'h3000] = 16'h5678;
        flag = 1'b0;
        for (int c = 5; c <= 8; c++) begin
            nextCycle();
            if (c == 5) checkOutput("b2b_idle_gap", busy, 1'b0);
            if (c == 6) applyStimulus(1'b0, 1'b0, 16'h3000, 16'h0000);
            if ((rdata !== 16'h1234) || mem_resp) flag = 1'b1;
        end
        checkOutput("b2b_rdata_stable", flag, 1'b0);
        nextCycle();
        checkOutput("b2b_second_resp", {mem_resp, rdata}, {1'b1, 16'h5678});
        nextCycle();

`ifdef MMIO_EN
        $display("[TB] MMIO read and write");
        applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'h0000);
        nextCycle();
        checkOutput("mmio_rd_c1", {busy, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 5'b11110);
        applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'h0000);
        nextCycle();
        checkOutput("mmio_rd_c2", {mem_resp, sram_ce_n, rdata}, {1'b1, 1'b1, 16'h00C3});
        nextCycle();
        runAccess(1'b0, 1'b1, 16'hFFFF, 16'h0F0F, lat, oe_low);
        checkOutput("mmio_wr_lat", lat, 32'd2);
        checkOutput("mmio_hex", hex_out, 16'h0F0F);
`else
        $display("[TB] 16'hFFFF as ordinary SRAM address");
        runAccess(1'b0, 1'b1, 16'hFFFF, 16'h1357, lat, oe_low);
        checkOutput("ffff_wr_lat", lat, 32'd5);
        runAccess(1'b1, 1'b0, 16'hFFFF, 16'h0000, lat, oe_low);
        checkOutput("ffff_rd_lat", lat, 32'd4);
        checkOutput("ffff_rd_data", rdata, 16'h1357);
        checkOutput("ffff_hex_zero", hex_out, 16'h0000);
`endif

        checkOutput("strobe_exclusive", illegal_seen, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
